// File: rtl/fpu_op_sequencer_64_pkg.sv
// Shared opcodes, state encoding and IEEE-754 double constants for the FPU op sequencer.
package fpu_op_sequencer_64_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned OP_W   = 2;
   localparam int unsigned CNT_W  = 8;

   localparam logic [OP_W-1:0] OP_ADDSUB  = 2'b00;
   localparam logic [OP_W-1:0] OP_UNARY   = 2'b01;
   localparam logic [OP_W-1:0] OP_MUL     = 2'b10;
   localparam logic [OP_W-1:0] OP_ILLEGAL = 2'b11;

   localparam logic [DATA_W-1:0] POS_INF      = 64'h7FF0000000000000;
   localparam logic [DATA_W-1:0] NEG_INF      = 64'hFFF0000000000000;
   localparam logic [DATA_W-1:0] ZERO         = 64'h0000000000000000;
   localparam logic [DATA_W-1:0] QNAN_DEFAULT = 64'h7FF8000000000000;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CHECK    = 3'd1,
      ST_DISPATCH = 3'd2,
      ST_WAIT     = 3'd3,
      ST_RESP     = 3'd4
   } state_e;

   // Registered request payload
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] data1;
      logic [DATA_W-1:0] data2;
   } req_t;

   // True for either signed infinity
   function automatic logic is_inf(input logic [DATA_W-1:0] v);
      return (v == POS_INF) || (v == NEG_INF);
   endfunction

endpackage

// File: rtl/fpu_special_detect_64.sv
// Combinational special-case decode: flags requests whose result is a quiet NaN without the AU.
module fpu_special_detect_64
   import fpu_op_sequencer_64_pkg::*;
(
   input  logic [OP_W-1:0]   operation,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   output logic              flag
);

   logic inf1;
   logic inf2;
   logic zero1;
   logic zero2;

   // Per-opcode NaN-producing operand patterns; -0 deliberately not treated as zero
   always_comb begin
      inf1  = is_inf(data1);
      inf2  = is_inf(data2);
      zero1 = (data1 == ZERO);
      zero2 = (data2 == ZERO);
      flag  = 1'b0;
      case (operation)
         OP_ADDSUB: flag = inf1 && inf2;
         OP_UNARY:  flag = inf1;
         OP_MUL:    flag = (zero1 && inf2) || (inf1 && zero2);
         default:   flag = 1'b0;
      endcase
   end

endmodule

// File: rtl/fpu_op_sequencer_64.sv
// Sequences one FPU request at a time: special-case screen, AU dispatch, bounded wait, response.
module fpu_op_sequencer_64
   import fpu_op_sequencer_64_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = 64,
   parameter logic [DATA_W-1:0] QNAN_VALUE     = QNAN_DEFAULT
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   operation,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   output logic              au_start,
   output logic [OP_W-1:0]   au_op,
   output logic [DATA_W-1:0] au_data1,
   output logic [DATA_W-1:0] au_data2,
   input  logic              au_done,
   input  logic [DATA_W-1:0] au_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_nan,
   output logic              res_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state;
   req_t             req_q;
   logic [CNT_W-1:0] cnt;
   logic             special;

   // Ready is a pure decode of the state register, held low while reset is asserted
   assign req_ready = (state == ST_IDLE) && rst_n;

   fpu_special_detect_64 u_detect (
      .operation (req_q.op),
      .data1     (req_q.data1),
      .data2     (req_q.data2),
      .flag      (special)
   );

   // Request FSM, AU command, timeout counter and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         req_q     <= '0;
         cnt       <= '0;
         au_start  <= 1'b0;
         au_op     <= '0;
         au_data1  <= '0;
         au_data2  <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_nan   <= 1'b0;
         res_err   <= 1'b0;
      end else begin
         au_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_q <= '{op: operation, data1: data1, data2: data2};
                  state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (req_q.op == OP_ILLEGAL) begin
                  res_data  <= '0;
                  res_nan   <= 1'b0;
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= ST_RESP;
               end else if (special) begin
                  res_data  <= QNAN_VALUE;
                  res_nan   <= 1'b1;
                  res_err   <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  au_start <= 1'b1;
                  au_op    <= req_q.op;
                  au_data1 <= req_q.data1;
                  au_data2 <= req_q.data2;
                  state    <= ST_DISPATCH;
               end
            end
            ST_DISPATCH: begin
               cnt   <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // Completion takes priority over a coincident timeout
               if (au_done) begin
                  res_data  <= au_result;
                  res_nan   <= 1'b0;
                  res_err   <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= ST_RESP;
               end else if (cnt == CNT_LAST) begin
                  res_data  <= QNAN_VALUE;
                  res_nan   <= 1'b0;
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fpu_op_sequencer_64.md
FPU_OP_SEQUENCER_64 -- requirements
Module: fpu_op_sequencer_64

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum number of cycles to wait for au_done (range 2..255).
REQ-002 The block SHALL have parameter QNAN_VALUE, default 64'h7FF8000000000000, giving the result word on a special-case or timeout abort.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports req_valid (input, 1) and req_ready (output, 1): the request handshake.
REQ-006 The block SHALL have ports operation (input, 2), data1 (input, 64) and data2 (input, 64): the request payload, with 00 = add/sub, 01 = single-operand op, 10 = multiply, 11 = illegal.
REQ-007 The block SHALL have ports au_start (output, 1), au_op (output, 2), au_data1 (output, 64) and au_data2 (output, 64): the command to the arithmetic unit.
REQ-008 The block SHALL have ports au_done (input, 1) and au_result (input, 64): the completion from the arithmetic unit.
REQ-009 The block SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, 64), res_nan (output, 1) and res_err (output, 1): the response handshake and payload.

Function
REQ-010 The FSM SHALL have the states IDLE, CHECK, DISPATCH, WAIT and RESP.
REQ-011 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, and operation, data1 and data2 are registered in that cycle.
REQ-012 On acceptance the FSM SHALL go IDLE -> CHECK.
REQ-013 In CHECK the special-case flag SHALL be computed from the registered operands (+inf = 64'h7FF0000000000000, -inf = 64'hFFF0000000000000, zero = 64'h0 only, never -0):
- op 00: both operands are infinities, any sign combination.
- op 01: data1 is ±inf.
- op 10: one operand is zero and the other is ±inf, either order.
REQ-014 From CHECK, op 11 SHALL go to RESP with res_data = 0, res_err = 1 and res_nan = 0.
REQ-015 From CHECK, a set flag SHALL go to RESP with res_data = QNAN_VALUE, res_nan = 1 and res_err = 0, and au_start SHALL never be asserted.
REQ-016 From CHECK, any other case SHALL go to DISPATCH.
REQ-017 In DISPATCH, au_start SHALL be 1 for exactly one cycle while au_op, au_data1 and au_data2 show the registered request, and the next state SHALL be WAIT.
REQ-018 au_op, au_data1 and au_data2 SHALL hold the registered request from DISPATCH through WAIT.
REQ-019 In WAIT, a timeout counter SHALL start at 0 on entry and increment every cycle.
REQ-020 In WAIT, au_done = 1 SHALL capture au_result into res_data (res_nan = 0, res_err = 0) and go to RESP.
REQ-021 In WAIT, when the counter reaches TIMEOUT_CYCLES-1 without au_done, the FSM SHALL go to RESP with res_data = QNAN_VALUE and res_err = 1.
REQ-022 When au_done and the timeout occur in the same cycle, au_done SHALL win.
REQ-023 au_done outside WAIT SHALL be ignored.
REQ-024 res_valid SHALL be 1 only in RESP, and res_data, res_nan and res_err SHALL be stable while res_valid = 1 and res_ready = 0.
REQ-025 res_valid && res_ready SHALL return the FSM to IDLE; req_ready rises the following cycle, so there is no same-cycle back-to-back acceptance.
REQ-026 Latency, acceptance edge to res_valid, SHALL be 2 cycles for special-case or illegal requests and 3 + (cycles until au_done) for dispatched requests.

Reset
REQ-027 rst_n = 0 SHALL asynchronously force: state IDLE, res_data = 0, au_data1 = 0, au_data2 = 0, au_op = 0, counter = 0, and au_start, res_valid, res_nan, res_err = 0.
REQ-028 req_ready SHALL be 0 during reset and SHALL follow REQ-011 once rst_n = 1.
REQ-029 Reset asserted mid-operation (WAIT or RESP) SHALL abandon the request without a response, and a later au_done SHALL be ignored (REQ-023).

Structure
REQ-030 A shared package SHALL hold the opcode constants (OP_ADDSUB, OP_UNARY, OP_MUL, OP_ILLEGAL), the state encoding, and the +inf, -inf, zero and default QNAN constants.
REQ-031 The special-case decode SHALL be one combinational sub-module, fpu_special_detect_64 (operation, data1, data2 -> flag), instantiated once; the FSM and counter stay in the top.

Verification
REQ-032 op 00 with data1 = 7FF0..0 and data2 = FFF0..0 -> res_valid at acceptance +2, res_data = 7FF8000000000000, res_nan = 1, au_start never asserted.
REQ-033 op 10 with data1 = 3FF0000000000000 and data2 = 4000000000000000, au_done asserted 5 cycles after au_start with au_result = 4000000000000000 -> one au_start pulse, res_data = 4000000000000000, res_nan = 0, res_err = 0.
REQ-034 op 01 with a normal operand and au_done never asserted, TIMEOUT_CYCLES = 8 -> RESP after 8 WAIT cycles, res_err = 1, res_data = QNAN_VALUE.
REQ-035 op 11 -> res_err = 1 and res_data = 0 at +2, followed by res_ready held low for 4 cycles -> outputs stable and req_ready = 0 throughout.
REQ-036 rst_n pulsed low during WAIT, then au_done = 1 -> all outputs at reset values, no res_valid, next request processed normally.
REQ-037 au_done coincident with the timeout cycle -> res_data = au_result, res_err = 0.
